// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 types, FSM states and helpers for the sequential float adder.
package fp16_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_WR, S_DONE
    } fas_state_t;

    localparam int          FP16_BIAS   = 15;
    localparam logic [15:0] FP16_MAXFIN = 16'h7BFF;

    // A mantissa needs work if it carried into bit 11, or lacks its hidden bit while exp can still drop.
    function automatic logic needs_norm(input logic [11:0] m, input logic [5:0] e);
        return m[11] || (!m[10] && e > 6'd1);
    endfunction

endpackage

// File: rtl/fp16_norm.sv
// fp16_norm: one normalization step on a 12-bit mantissa/exponent pair.
module fp16_norm
    import fp16_pkg::*;
(
    input  logic [11:0] mant_i,
    input  logic [5:0]  exp_i,
    output logic [11:0] mant_o,
    output logic [5:0]  exp_o,
    output logic        finished_o
);

    always_comb begin
        mant_o = mant_i;
        exp_o  = exp_i;
        if (mant_i[11]) begin
            mant_o = mant_i >> 1;
            exp_o  = exp_i + 6'd1;
        end else if (!mant_i[10] && exp_i > 6'd1) begin
            mant_o = mant_i << 1;
            exp_o  = exp_i - 6'd1;
        end
        finished_o = !needs_norm(mant_o, exp_o);
    end

endmodule

// File: rtl/fltadd_seq.sv
// fltadd_seq: multi-cycle FP16 adder that reads its operands from and writes its
// result to a byte-wide data memory, truncating at every step.
module fltadd_seq
    import fp16_pkg::*;
#(
    parameter logic [7:0]  OP_BASE   = 8'd128,
    parameter logic [7:0]  RES_BASE  = 8'd132,
    parameter int unsigned MAX_ALIGN = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       done
);

    fas_state_t  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op_q, op_d;
    logic        a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [5:0]  a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [11:0] a_mant_q, a_mant_d, b_mant_q, b_mant_d;
    logic [15:0] res_q, res_d;

    fp16_t       x, y;
    logic [11:0] xm, ym, sum, n_mant;
    logic [5:0]  n_exp;
    logic        n_fin, swap;
    logic [4:0]  pack_exp;

    assign x        = op_q[31:16];
    assign y        = op_q[15:0];
    assign xm       = {1'b0, |x.exp, x.frac};
    assign ym       = {1'b0, |y.exp, y.frac};
    assign swap     = {y.exp, ym} > {x.exp, xm};
    assign sum      = (a_sign_q == b_sign_q) ? a_mant_q + b_mant_q : a_mant_q - b_mant_q;
    // A mantissa with its hidden bit set at raw exponent 0 has reached the smallest normal.
    assign pack_exp = (a_exp_q == 6'd0) ? 5'd1 : a_exp_q[4:0];

    fp16_norm u_norm (
        .mant_i    (a_mant_q),
        .exp_i     (a_exp_q),
        .mant_o    (n_mant),
        .exp_o     (n_exp),
        .finished_o(n_fin)
    );

    assign busy      = state_q != S_IDLE && state_q != S_DONE;
    assign done      = state_q == S_DONE;
    assign mem_we    = state_q == S_WR;
    assign mem_addr  = (state_q == S_RD && cnt_q < 4'd4) ? OP_BASE + {4'd0, cnt_q} :
                       mem_we ? RES_BASE + {4'd0, cnt_q} : 8'd0;
    assign mem_wdata = mem_we ? (cnt_q[0] ? res_q[7:0] : res_q[15:8]) : 8'd0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_sign_d = a_sign_q;
        a_exp_d  = a_exp_q;
        a_mant_d = a_mant_q;
        b_sign_d = b_sign_q;
        b_exp_d  = b_exp_q;
        b_mant_d = b_mant_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (start) state_d = S_RD;
            end
            S_RD: begin
                // Read data lags the address by a cycle, so byte k lands during count k+1.
                cnt_d = cnt_q + 4'd1;
                if (cnt_q != 4'd0) op_d = {op_q[23:0], mem_rdata};
                if (cnt_q == 4'd4) begin
                    cnt_d   = 4'd0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                {a_sign_d, a_exp_d, a_mant_d, b_sign_d, b_exp_d, b_mant_d} = swap ?
                    {y.sign, 1'b0, y.exp, ym, x.sign, 1'b0, x.exp, xm} :
                    {x.sign, 1'b0, x.exp, xm, y.sign, 1'b0, y.exp, ym};
                cnt_d   = 4'd0;
                state_d = (x.exp == y.exp) ? S_ADD : S_ALIGN;
            end
            S_ALIGN: begin
                b_mant_d = b_mant_q >> 1;
                b_exp_d  = b_exp_q + 6'd1;
                cnt_d    = cnt_q + 4'd1;
                if (b_exp_d == a_exp_q) begin
                    state_d = S_ADD;
                end else if (cnt_d == 4'(MAX_ALIGN)) begin
                    b_mant_d = 12'd0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                a_mant_d = sum;
                if (sum == 12'd0) begin
                    a_sign_d = 1'b0;
                    a_exp_d  = 6'd0;
                    state_d  = S_PACK;
                end else begin
                    state_d = needs_norm(sum, a_exp_q) ? S_NORM : S_PACK;
                end
            end
            S_NORM: begin
                a_mant_d = n_mant;
                a_exp_d  = n_exp;
                if (n_fin) state_d = S_PACK;
            end
            S_PACK: begin
                res_d   = (a_exp_q > 6'd30) ? {a_sign_q, FP16_MAXFIN[14:0]} :
                          {a_sign_q, a_mant_q[10] ? pack_exp : 5'd0, a_mant_q[9:0]};
                cnt_d   = 4'd0;
                state_d = S_WR;
            end
            S_WR: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) state_d = S_DONE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            op_q     <= 32'd0;
            a_sign_q <= 1'b0;
            a_exp_q  <= 6'd0;
            a_mant_q <= 12'd0;
            b_sign_q <= 1'b0;
            b_exp_q  <= 6'd0;
            b_mant_q <= 12'd0;
            res_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_sign_q <= a_sign_d;
            a_exp_q  <= a_exp_d;
            a_mant_q <= a_mant_d;
            b_sign_q <= b_sign_d;
            b_exp_q  <= b_exp_d;
            b_mant_q <= b_mant_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_fltadd_seq.sv
// tb_fltadd_seq: randomized and directed scoreboard bench for fltadd_seq with an
// arithmetic FP16 reference model and a byte-wide synchronous memory.
module tb_fltadd_seq;

    localparam int MAX_ALIGN = 12;

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          issue;
    } exp_t;

    logic       clk = 0, reset = 0, start = 0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, busy, done;
    logic [7:0] mem [256];
    int         cyc = 0, tests = 0, fails = 0, we_cnt = 0;
    logic       prev_done = 0;
    exp_t       scb [$];

    fltadd_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: real-valued FP16 add rules with integer mantissas and truncation.
    function automatic void model(input logic [15:0] p, input logic [15:0] q,
                                  output logic [15:0] r, output int lat);
        int ex, ey, mx, my, ea, eb, ma, mb, d, sh, s, e, nn;
        logic sa, sbit;
        ex = int'(p[14:10]);
        ey = int'(q[14:10]);
        mx = (ex != 0 ? 1024 : 0) + int'(p[9:0]);
        my = (ey != 0 ? 1024 : 0) + int'(q[9:0]);
        if (ex * 2048 + mx >= ey * 2048 + my) begin
            ea = ex; ma = mx; sa = p[15]; eb = ey; mb = my; sbit = q[15];
        end else begin
            ea = ey; ma = my; sa = q[15]; eb = ex; mb = mx; sbit = p[15];
        end
        d  = ea - eb;
        sh = d < MAX_ALIGN ? d : MAX_ALIGN;
        mb = d > MAX_ALIGN ? 0 : mb >> d;
        s  = (sa == sbit) ? ma + mb : ma - mb;
        e  = ea;
        nn = 0;
        if (s == 0) begin
            r = 16'h0000;
        end else begin
            if (s >= 2048) begin
                s = s / 2; e++; nn = 1;
            end else begin
                while (s < 1024 && e > 1) begin
                    s = s * 2; e--; nn++;
                end
            end
            if (e > 30) r = {sa, 15'h7BFF};
            else r = {sa, 5'(s >= 1024 ? (e == 0 ? 1 : e) : 0), 10'(s % 1024)};
        end
        lat = 5 + 1 + sh + 1 + nn + 1 + 2;
    endfunction

    task automatic run_op(input logic [15:0] p, input logic [15:0] q, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        mem[128] = p[15:8];
        mem[129] = p[7:0];
        mem[130] = q[15:8];
        mem[131] = q[7:0];
        model(p, q, e.res, e.lat);
        e.issue = cyc;
        scb.push_back(e);
        start = 1;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            fails++;
            tests++;
            $display("FAIL done_timeout: op %h+%h never raised done", p, q);
            void'(scb.pop_back());
        end
        repeat (hold) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_busy", 32'(busy), 32'd0);
        end
        start = 0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (done && !prev_done) begin
                if (scb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected none pending");
                end else begin
                    e = scb.pop_front();
                    chk("result", 32'({mem[132], mem[133]}), 32'(e.res));
                    chk("latency", 32'(cyc - e.issue - 1), 32'(e.lat));
                    chk("we_pulses", 32'(we_cnt), 32'd2);
                    chk("busy_in_done", 32'(busy), 32'd0);
                end
                we_cnt = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        logic [7:0] r0, r1;
        logic [15:0] dir_p [7] = '{16'h1A04, 16'h4204, 16'h4A10, 16'h4204, 16'h7800, 16'h7BFF, 16'h0001};
        logic [15:0] dir_q [7] = '{16'h1A04, 16'h4204, 16'h4204, 16'hC204, 16'h0400, 16'h7BFF, 16'h0001};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        reset = 1;
        for (int i = 0; i < 7; i++) run_op(dir_p[i], dir_q[i], (i == 0) ? 3 : 0);

        @(negedge clk);
        mem[128] = 8'h78; mem[129] = 8'h00; mem[130] = 8'h04; mem[131] = 8'h00;
        r0 = mem[132];
        r1 = mem[133];
        start = 1;
        repeat (9) @(negedge clk);
        chk("align_busy", 32'(busy), 32'd1);
        reset = 0;
        start = 0;
        @(negedge clk);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        reset = 1;
        repeat (20) @(negedge clk);
        chk("abort_res_msb", 32'(mem[132]), 32'(r0));
        chk("abort_res_lsb", 32'(mem[133]), 32'(r1));
        chk("abort_we_cnt", 32'(we_cnt), 32'd0);
        chk("abort_idle_done", 32'(done), 32'd0);
        run_op(16'h4A10, 16'h4204, 0);

        for (int i = 0; i < 60; i++) run_op(16'($urandom), 16'($urandom), i % 7 == 0 ? 1 : 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(scb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fltadd_seq.md
# fltadd_seq

Multi-cycle FP16 (1/5/10, bias 15) adder sequencer. It owns the byte-wide data-memory port while active. It fetches two operands from fixed addresses, performs an iterative align/add/normalize, writes the 16-bit result back, and raises `done`. It sits beside the data memory as the float-add engine for the `pMux` float-add program slot, and the benches poll its `done` and memory locations 132–133.

## Interface
- `OP_BASE`, default 128: byte address of operand 1 MSB. Layout is op1 MSB/LSB, then op2 MSB/LSB, at `OP_BASE`..`OP_BASE+3`.
- `RES_BASE`, default 132: byte address of result MSB; result LSB is at `RES_BASE+1`.
- `MAX_ALIGN`, default 12: cap on alignment shift cycles.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-low; `reset=0` resets on the next rising edge.
- `start`  in  1: level request; sampled in IDLE.
- `mem_addr`  out  8: byte address.
- `mem_we`  out  1: write strobe, one byte per cycle.
- `mem_wdata`  out  8: write data.
- `mem_rdata`  in  8: read data, valid one cycle after `mem_addr` is presented.
- `busy`  out  1: high in every state except IDLE and DONE.
- `done`  out  1: high only in DONE.

## Operation
- **FSM states:** IDLE → RD → UNPACK → ALIGN → ADD → NORM → PACK → WR → DONE → IDLE.
- **IDLE:** waits for `start=1`, then goes to RD.
- **RD:** presents `OP_BASE+0..3` on consecutive cycles and captures each byte one cycle later. Takes 5 cycles.
- **UNPACK:**
  - Hidden bit = OR of exponent field; mantissa is 11 bits.
  - Exponent 0 is treated as zero/denormal with hidden bit 0.
  - Swap operands so A has the larger magnitude, comparing {exp, mant}.
- **ALIGN:**
  - Shift B's mantissa right by 1 per cycle until the exponents match.
  - Stop after `MAX_ALIGN` cycles; if the difference is larger, B's mantissa is forced to 0.
  - Shifted-out bits are discarded (truncate).
- **ADD:**
  - 12-bit result: A+B if signs are equal, else A−B.
  - Result sign = A's sign.
  - A zero result gives sign 0 and jumps straight to PACK with 0x0000.
- **NORM:**
  - On bit 11 carry: shift right 1 and exp+1, in one cycle.
  - Otherwise, while bit 10 = 0 and exp > 1: shift left 1 and exp−1 per cycle.
  - If bit 10 is still 0 at exp = 1, encode exponent 0 (denormal).
- **PACK:**
  - If exp > 30: saturate to {sign, 0x7BFF}.
  - Inf and NaN inputs are treated as ordinary finite values; no special encoding.
- **WR:** writes the MSB to `RES_BASE`, then the LSB to `RES_BASE+1`, on consecutive cycles.
- **DONE:** holds `done=1` while `start=1`; on `start=0`, goes to IDLE the next cycle.
- **Rounding:** round toward zero throughout.

## Timing
- **Reset values:** `done=0`, `busy=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, state = IDLE.
- **Reset mid-operation:**
  - Outputs take reset values on the next edge; any write not yet issued never occurs.
  - A write already issued stays in memory.
- **`mem_we` timing:** high for exactly 2 cycles per operation, only in WR.
- **Latency, `start` sampled high to `done` rising:**
  - 5 (RD) + 1 (UNPACK) + a (ALIGN) + 1 (ADD) + n (NORM) + 1 (PACK) + 2 (WR) cycles.
  - a = min(|expA−expB|, `MAX_ALIGN`); ALIGN occupies 0 cycles when a = 0.
  - n = 0..11; NORM takes 1 cycle for a carry and 0 cycles if already normalized.
  - Worst case is 33 cycles.
- **`start` held high after `done`:** no restart until `start` drops for at least one cycle.
- **`start` changing while busy:** ignored.

## Structure
- **Package `fp16_pkg`:**
  - `fp16_t` packed struct {sign, exp[4:0], frac[9:0]}.
  - State enum `fas_state_t`.
  - Constants `FP16_BIAS=15`, `FP16_MAXFIN=16'h7BFF`.
- **Sub-module `fp16_norm`:** one-step normalizer; takes {mant12, exp} and returns the next {mant12, exp, finished}. It is used iteratively by NORM.

## Test plan
- Operands 0x1A04 + 0x1A04 → 0x1E04 at [132]=0x1E, [133]=0x04; `done` after 11 cycles.
- 0x4204 + 0x4204 → 0x4604. Then 0x4A10 + 0x4204 → a=2 align, checked against a bit-exact truncating model.
- 0x4204 + 0xC204 → 0x0000 with sign 0; NORM is skipped.
- 0x7800 + 0x0400 (exp difference 29) → 0x7800. ALIGN lasts exactly 12 cycles and total latency is bounded at ≤33.
- 0x7BFF + 0x7BFF → 0x7BFF (saturation). 0x0001 + 0x0001 → 0x0002 (denormal path).
- Pull `reset` low during ALIGN → `done=0` and `mem_we=0` next cycle; [132..133] unchanged. A fresh `start` then completes normally.
